// File: rtl/pll_rate_pkg.sv
// Shared register map and FSM state encoding for the PLL rate switcher.
// Imported by the sequencer top level.
package pll_rate_pkg;

    localparam logic [5:0] REG_MODE  = 6'd0;
    localparam logic [5:0] REG_START = 6'd2;
    localparam logic [5:0] REG_MFRAC = 6'd7;

    typedef enum logic [2:0] {
        IDLE,
        W_MODE,
        GAP1,
        W_FRAC,
        GAP2,
        W_START,
        W_UNLOCK,
        W_LOCK
    } rate_state_t;

endpackage

// File: rtl/pll_rate_switcher_sync2.sv
// Two-flop synchronizer for a single asynchronous level into clk_sys.
// Both stages clear to 0 on reset.
module sync2 (
    input  logic clk_sys,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta;

    // Two-stage capture of the asynchronous level.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/pll_rate_switcher.sv
// Drives the PLL reconfig Avalon-MM port to switch the fractional-M word
// between native and 60 Hz adjust rates, then waits for relock.
module pll_rate_switcher
    import pll_rate_pkg::*;
#(
    parameter logic [31:0] FRAC_NATIVE  = 32'd3639383488,
    parameter logic [31:0] FRAC_ALT     = 32'd3262113561,
    parameter int          GAP          = 3,
    parameter int          LOCK_TIMEOUT = 65535
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic        sel_alt,
    input  logic        locked,
    input  logic        cfg_waitrequest,
    output logic        cfg_write,
    output logic [5:0]  cfg_address,
    output logic [31:0] cfg_data,
    output logic        applied,
    output logic        busy,
    output logic        done,
    output logic        error
);

    localparam logic [3:0]  GAP_LD = 4'(GAP);
    localparam logic [15:0] TMO_LD = 16'(LOCK_TIMEOUT);

    rate_state_t state, state_n;
    logic        sel_s, sel_d, lock_s;
    logic [3:0]  gap_cnt;
    logic [15:0] tmo_cnt;
    logic        trig, gap_ld, tmo_ld, done_n, err_set;

    sync2 u_sync_sel (
        .clk_sys (clk_sys),
        .reset   (reset),
        .d       (sel_alt),
        .q       (sel_s)
    );

    sync2 u_sync_lock (
        .clk_sys (clk_sys),
        .reset   (reset),
        .d       (locked),
        .q       (lock_s)
    );

    // State, counters and sticky status registers.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            sel_d   <= 1'b0;
            applied <= 1'b0;
            done    <= 1'b0;
            error   <= 1'b0;
            gap_cnt <= 4'd0;
            tmo_cnt <= 16'd0;
        end else begin
            state <= state_n;
            sel_d <= sel_s;
            done  <= done_n;
            if (trig) begin
                applied <= sel_d;
                error   <= 1'b0;
            end else if (err_set) begin
                error <= 1'b1;
            end
            if (gap_ld) begin
                gap_cnt <= GAP_LD;
            end else if ((state == GAP1 || state == GAP2) && gap_cnt != 4'd0) begin
                gap_cnt <= gap_cnt - 4'd1;
            end
            if (tmo_ld) begin
                tmo_cnt <= TMO_LD;
            end else if ((state == W_UNLOCK || state == W_LOCK) && tmo_cnt != 16'd0) begin
                tmo_cnt <= tmo_cnt - 16'd1;
            end
        end
    end

    // Next-state decode and Avalon-MM write outputs.
    always_comb begin
        state_n     = state;
        cfg_write   = 1'b0;
        cfg_address = 6'd0;
        cfg_data    = 32'd0;
        busy        = (state != IDLE);
        trig        = 1'b0;
        gap_ld      = 1'b0;
        tmo_ld      = 1'b0;
        done_n      = 1'b0;
        err_set     = 1'b0;
        unique case (state)
            IDLE: begin
                if (sel_s == sel_d && sel_d != applied) begin
                    trig    = 1'b1;
                    state_n = W_MODE;
                end
            end
            W_MODE: begin
                cfg_write   = 1'b1;
                cfg_address = REG_MODE;
                if (!cfg_waitrequest) begin
                    gap_ld  = 1'b1;
                    state_n = GAP1;
                end
            end
            GAP1: begin
                if (gap_cnt <= 4'd1) state_n = W_FRAC;
            end
            W_FRAC: begin
                cfg_write   = 1'b1;
                cfg_address = REG_MFRAC;
                cfg_data    = applied ? FRAC_ALT : FRAC_NATIVE;
                if (!cfg_waitrequest) begin
                    gap_ld  = 1'b1;
                    state_n = GAP2;
                end
            end
            GAP2: begin
                if (gap_cnt <= 4'd1) state_n = W_START;
            end
            W_START: begin
                cfg_write   = 1'b1;
                cfg_address = REG_START;
                if (!cfg_waitrequest) begin
                    tmo_ld  = 1'b1;
                    state_n = W_UNLOCK;
                end
            end
            W_UNLOCK: begin
                if (!lock_s || tmo_cnt == 16'd0) begin
                    tmo_ld  = 1'b1;
                    state_n = W_LOCK;
                end
            end
            W_LOCK: begin
                if (lock_s) begin
                    done_n  = 1'b1;
                    state_n = IDLE;
                end else if (tmo_cnt == 16'd0) begin
                    err_set = 1'b1;
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

endmodule

// File: tb/tb_pll_rate_switcher.sv
// Directed self-checking bench for pll_rate_switcher with a simple PLL
// model that drops lock for 20 cycles after each START write.
module tb_pll_rate_switcher;

    localparam logic [31:0] F_NAT = 32'd3639383488;
    localparam logic [31:0] F_ALT = 32'd3262113561;

    logic        clk_sys = 1'b0;
    logic        reset;
    logic        sel_alt;
    logic        cfg_waitrequest;
    logic        locked;
    logic        cfg_write;
    logic [5:0]  cfg_address;
    logic [31:0] cfg_data;
    logic        applied, busy, done, error;

    bit          pll_dead = 1'b0;
    int          drop_cnt = 0;
    int          cyc = 0;
    int          wr_n = 0;
    int          st_n = 0;
    int          done_cnt = 0;
    logic        prev_wr = 1'b0;
    logic [5:0]  wr_addr [64];
    logic [31:0] wr_data [64];
    int          st_cyc  [64];

    int checks = 0;
    int failures = 0;

    assign locked = !pll_dead && (drop_cnt == 0);

    always #10 clk_sys = ~clk_sys;

    pll_rate_switcher #(
        .LOCK_TIMEOUT (100)
    ) dut (
        .clk_sys         (clk_sys),
        .reset           (reset),
        .sel_alt         (sel_alt),
        .locked          (locked),
        .cfg_waitrequest (cfg_waitrequest),
        .cfg_write       (cfg_write),
        .cfg_address     (cfg_address),
        .cfg_data        (cfg_data),
        .applied         (applied),
        .busy            (busy),
        .done            (done),
        .error           (error)
    );

    // Bus monitor and PLL lock model.
    always @(posedge clk_sys) begin
        cyc     <= cyc + 1;
        prev_wr <= cfg_write;
        if (cfg_write && !prev_wr && st_n < 64) begin
            st_cyc[st_n] <= cyc;
            st_n         <= st_n + 1;
        end
        if (cfg_write && !cfg_waitrequest && wr_n < 64) begin
            wr_addr[wr_n] <= cfg_address;
            wr_data[wr_n] <= cfg_data;
            wr_n          <= wr_n + 1;
        end
        if (cfg_write && !cfg_waitrequest && cfg_address == 6'd2)
            drop_cnt <= 20;
        else if (drop_cnt > 0)
            drop_cnt <= drop_cnt - 1;
        if (done) done_cnt <= done_cnt + 1;
    end

    task automatic wait_writes(input int n, input int lim, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < lim; i++) begin
            @(negedge clk_sys);
            if (wr_n >= n) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_done(input int n, input int lim, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < lim; i++) begin
            @(negedge clk_sys);
            if (done_cnt >= n) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        sel_alt = 1'b0;
        cfg_waitrequest = 1'b0;
        pll_dead = 1'b0;
        repeat (3) @(negedge clk_sys);
        checks++;
        if ({cfg_write, busy, applied, done, error} !== 5'b0) begin
            failures++;
            $display("FAIL reset_flags: got %b want 00000",
                     {cfg_write, busy, applied, done, error});
        end
        checks++;
        if (cfg_address !== 6'd0 || cfg_data !== 32'd0) begin
            failures++;
            $display("FAIL reset_bus: got addr=%0d data=%0d want 0 0",
                     cfg_address, cfg_data);
        end
        reset = 1'b0;
        repeat (1000) @(negedge clk_sys);
        checks++;
        if (wr_n !== 0 || st_n !== 0) begin
            failures++;
            $display("FAIL idle_no_write: got writes=%0d starts=%0d want 0 0", wr_n, st_n);
        end
        checks++;
        if (applied !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL idle_state: got applied=%b busy=%b want 0 0", applied, busy);
        end
    endtask

    task automatic test_switch_alt;
        int b, sb, bd, n0;
        bit ok;
        b = wr_n;
        sb = st_n;
        bd = done_cnt;
        sel_alt = 1'b1;
        n0 = cyc;
        wait_done(bd + 1, 300, ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL alt_done_wait: got timeout want done");
        end
        repeat (5) @(negedge clk_sys);
        checks++;
        if (wr_n - b !== 3) begin
            failures++;
            $display("FAIL alt_count: got %0d want 3", wr_n - b);
        end
        checks++;
        if (wr_addr[b] !== 6'd0 || wr_data[b] !== 32'd0) begin
            failures++;
            $display("FAIL alt_w0: got %0d,%0d want 0,0", wr_addr[b], wr_data[b]);
        end
        checks++;
        if (wr_addr[b+1] !== 6'd7 || wr_data[b+1] !== F_ALT) begin
            failures++;
            $display("FAIL alt_w1: got %0d,%0d want 7,%0d", wr_addr[b+1], wr_data[b+1], F_ALT);
        end
        checks++;
        if (wr_addr[b+2] !== 6'd2 || wr_data[b+2] !== 32'd0) begin
            failures++;
            $display("FAIL alt_w2: got %0d,%0d want 2,0", wr_addr[b+2], wr_data[b+2]);
        end
        checks++;
        if (st_cyc[sb] - n0 !== 4 || st_cyc[sb+1] - n0 !== 8 || st_cyc[sb+2] - n0 !== 12) begin
            failures++;
            $display("FAIL alt_timing: got %0d,%0d,%0d want 4,8,12",
                     st_cyc[sb] - n0, st_cyc[sb+1] - n0, st_cyc[sb+2] - n0);
        end
        checks++;
        if (done_cnt - bd !== 1) begin
            failures++;
            $display("FAIL alt_done_once: got %0d want 1", done_cnt - bd);
        end
        checks++;
        if (applied !== 1'b1 || busy !== 1'b0 || error !== 1'b0) begin
            failures++;
            $display("FAIL alt_final: got applied=%b busy=%b error=%b want 1 0 0",
                     applied, busy, error);
        end
    endtask

    task automatic test_waitrequest;
        int b, bd;
        bit ok;
        b = wr_n;
        bd = done_cnt;
        sel_alt = 1'b0;
        wait_writes(b + 1, 50, ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL wr_mode_wait: got timeout want mode write");
        end
        cfg_waitrequest = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk_sys);
            if (cfg_write) begin
                ok = 1'b1;
                break;
            end
        end
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL wr_frac_wait: got timeout want frac write");
        end
        for (int i = 0; i < 6; i++) begin
            if (i > 0) @(negedge clk_sys);
            checks++;
            if (cfg_write !== 1'b1 || cfg_address !== 6'd7 || cfg_data !== F_NAT) begin
                failures++;
                $display("FAIL wr_hold_%0d: got w=%b a=%0d d=%0d want 1 7 %0d",
                         i, cfg_write, cfg_address, cfg_data, F_NAT);
            end
        end
        cfg_waitrequest = 1'b0;
        @(negedge clk_sys);
        checks++;
        if (cfg_write !== 1'b0 || wr_n - b !== 2 || wr_addr[b+1] !== 6'd7) begin
            failures++;
            $display("FAIL wr_accept_once: got w=%b n=%0d a=%0d want 0 2 7",
                     cfg_write, wr_n - b, wr_addr[b+1]);
        end
        wait_done(bd + 1, 300, ok);
        checks++;
        if (!ok || applied !== 1'b0) begin
            failures++;
            $display("FAIL wr_final: got ok=%b applied=%b want 1 0", ok, applied);
        end
    endtask

    task automatic test_toggle_lock;
        int b, bd;
        bit ok;
        b = wr_n;
        bd = done_cnt;
        sel_alt = 1'b1;
        wait_writes(b + 3, 100, ok);
        repeat (10) @(negedge clk_sys);
        checks++;
        if (!ok || busy !== 1'b1) begin
            failures++;
            $display("FAIL tog_in_lock: got ok=%b busy=%b want 1 1", ok, busy);
        end
        sel_alt = 1'b0;
        wait_done(bd + 2, 400, ok);
        repeat (5) @(negedge clk_sys);
        checks++;
        if (!ok || done_cnt - bd !== 2 || wr_n - b !== 6) begin
            failures++;
            $display("FAIL tog_count: got done=%0d writes=%0d want 2 6",
                     done_cnt - bd, wr_n - b);
        end
        checks++;
        if (wr_data[b+1] !== F_ALT || wr_addr[b+4] !== 6'd7 || wr_data[b+4] !== F_NAT) begin
            failures++;
            $display("FAIL tog_data: got %0d,%0d@%0d want %0d,%0d@7",
                     wr_data[b+1], wr_data[b+4], wr_addr[b+4], F_ALT, F_NAT);
        end
        checks++;
        if (applied !== 1'b0) begin
            failures++;
            $display("FAIL tog_applied: got %b want 0", applied);
        end
    endtask

    task automatic test_timeout;
        int bd;
        bit ok;
        bd = done_cnt;
        pll_dead = 1'b1;
        sel_alt = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk_sys);
            if (error) begin
                ok = 1'b1;
                break;
            end
        end
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL tmo_error: got error=%b want 1", error);
        end
        checks++;
        if (done_cnt !== bd || busy !== 1'b0 || applied !== 1'b1) begin
            failures++;
            $display("FAIL tmo_state: got done=%0d busy=%b applied=%b want 0 0 1",
                     done_cnt - bd, busy, applied);
        end
        pll_dead = 1'b0;
        sel_alt = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk_sys);
            if (busy) begin
                ok = 1'b1;
                break;
            end
        end
        checks++;
        if (!ok || error !== 1'b0) begin
            failures++;
            $display("FAIL tmo_clear: got busy=%b error=%b want 1 0", ok, error);
        end
        wait_done(bd + 1, 300, ok);
        checks++;
        if (!ok || error !== 1'b0 || applied !== 1'b0) begin
            failures++;
            $display("FAIL tmo_recover: got ok=%b error=%b applied=%b want 1 0 0",
                     ok, error, applied);
        end
    endtask

    task automatic test_reset_mid;
        int b, b2, bd;
        bit ok;
        b = wr_n;
        sel_alt = 1'b1;
        wait_writes(b + 1, 50, ok);
        checks++;
        if (!ok || busy !== 1'b1 || cfg_write !== 1'b0) begin
            failures++;
            $display("FAIL rst_in_gap: got ok=%b busy=%b w=%b want 1 1 0", ok, busy, cfg_write);
        end
        reset = 1'b1;
        #1;
        checks++;
        if (cfg_write !== 1'b0 || busy !== 1'b0 || applied !== 1'b0) begin
            failures++;
            $display("FAIL rst_async: got w=%b busy=%b applied=%b want 0 0 0",
                     cfg_write, busy, applied);
        end
        @(negedge clk_sys);
        reset = 1'b0;
        b2 = wr_n;
        bd = done_cnt;
        checks++;
        if (b2 !== b + 1) begin
            failures++;
            $display("FAIL rst_dropped: got %0d want %0d", b2, b + 1);
        end
        wait_done(bd + 1, 300, ok);
        checks++;
        if (!ok || wr_n - b2 !== 3 || wr_addr[b2] !== 6'd0 || wr_addr[b2+1] !== 6'd7
            || wr_data[b2+1] !== F_ALT || wr_addr[b2+2] !== 6'd2) begin
            failures++;
            $display("FAIL rst_rerun: got ok=%b n=%0d a0=%0d a1=%0d d1=%0d a2=%0d want 1 3 0 7 %0d 2",
                     ok, wr_n - b2, wr_addr[b2], wr_addr[b2+1], wr_data[b2+1], wr_addr[b2+2], F_ALT);
        end
        checks++;
        if (applied !== 1'b1) begin
            failures++;
            $display("FAIL rst_applied: got %b want 1", applied);
        end
    endtask

    initial begin
        test_reset();
        test_switch_alt();
        test_waitrequest();
        test_toggle_lock();
        test_timeout();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pll_rate_switcher.md
# pll_rate_switcher

Reconfiguration sequencer that drives the PLL management (Avalon-MM) port of the reconfig block feeding the 49.152 MHz core clock. It sits directly upstream of the PLL reconfig controller on the 50 MHz management clock. It turns a level request from the OSD status word ("60Hz Adjust" game-speed option) into the fractional-M write sequence, then waits for the PLL to relock. It exposes busy, done and error status to the top level.

## Interface
Parameters:
- `FRAC_NATIVE`, 32'd3639383488: M-counter fractional word for native speed
- `FRAC_ALT`, 32'd3262113561: fractional word for ~1% underclock (60 Hz adjust)
- `GAP`, 3: idle cycles between consecutive register writes (1..15)
- `LOCK_TIMEOUT`, 65535: max cycles to wait for each locked edge

Ports:
- `clk_sys` in 1: management clock (CLK_50M domain)
- `reset` in 1: asynchronous, active-high
- `sel_alt` in 1: requested rate, asynchronous to `clk_sys` (0 native, 1 alt)
- `locked` in 1: PLL locked, asynchronous
- `cfg_waitrequest` in 1: Avalon-MM waitrequest from reconfig block
- `cfg_write` out 1: Avalon-MM write strobe
- `cfg_address` out 6: register address
- `cfg_data` out 32: write data
- `applied` out 1: rate currently programmed or being programmed
- `busy` out 1: sequence in progress
- `done` out 1: one-cycle pulse on successful relock
- `error` out 1: sticky relock timeout; cleared at the next trigger

## Operation
- Reset values: `cfg_write`=0, `cfg_address`=0, `cfg_data`=0, `applied`=0 (matches PLL power-up config), `busy`=0, `done`=0, `error`=0, FSM=IDLE.
- `sel_alt` and `locked` each pass through a 2-FF synchronizer (`sel_s`, `lock_s`). A third register `sel_d` holds the previous `sel_s`.
- Trigger, evaluated only in IDLE: `sel_s==sel_d && sel_d!=applied`. On trigger: `applied<=sel_d`, `error<=0`, go to W_MODE.
- FSM states: IDLE, W_MODE, GAP1, W_FRAC, GAP2, W_START, W_UNLOCK, W_LOCK.
- W_MODE writes addr 0, data 0 (waitrequest mode). W_FRAC writes addr 7, data `applied ? FRAC_ALT : FRAC_NATIVE`. W_START writes addr 2, data 0.
- Write handshake: on state entry, `cfg_write`=1 with address and data stable. They are held while `cfg_waitrequest`=1. The write completes in the first cycle with `cfg_write`=1 and `cfg_waitrequest`=0. `cfg_write` is 0 on the next cycle and the FSM advances.
- GAPn: a 4-bit counter loaded with `GAP` counts down to 0, then the FSM moves to the next write.
- W_UNLOCK: wait for `lock_s`=0. W_LOCK: wait for `lock_s`=1, then pulse `done`, go to IDLE.
- The 16-bit timeout counter reloads on entry to W_UNLOCK and again on entry to W_LOCK.
- If W_UNLOCK times out (the PLL never dropped lock), go to W_LOCK; this is not an error.
- If W_LOCK times out, set `error`=1, go to IDLE, and do not pulse `done`.
- `busy`=1 in every state except IDLE.
- A change of `sel_alt` during a sequence is ignored until IDLE. It is then retriggered if it still differs from `applied`.
- Asynchronous reset mid-sequence aborts immediately. All outputs return to reset values and the partial write is dropped. If `sel_alt`=1 after reset, the sequence reruns automatically.

## Timing
- Request to trigger: at most 4 `clk_sys` edges after `sel_alt` settles (2 sync + 1 compare + 1 decision).
- First `cfg_write` is high in the cycle after trigger.
- With `cfg_waitrequest`=0 throughout, the interval from one write start to the next is `1+GAP` cycles. With `GAP`=3, the three writes start at cycles T+1, T+5 and T+9.
- `done` is high exactly 1 cycle, in the cycle after `lock_s` is sampled 1 in W_LOCK.
- `locked` to `lock_s` latency is 2 cycles.

## Structure
- Package `pll_rate_pkg` holds:
  - `REG_MODE`=6'd0, `REG_START`=6'd2, `REG_MFRAC`=6'd7
  - enum `rate_state_t` for the FSM states
- Sub-module `sync2` (2-FF synchronizer, reset to 0), instantiated for `sel_alt` and `locked`.
- Target size: roughly 150–200 lines of RTL.

## Test plan
- Reset, `sel_alt`=0, `locked`=1 -> no `cfg_write` for 1000 cycles; `applied`=0, `busy`=0.
- `sel_alt` 0→1, `cfg_waitrequest`=0, `locked` dropped for 20 cycles after the START write, `GAP`=3 -> writes (0,0), (7,3262113561), (2,0) at T+1, T+5, T+9; `done` pulses once; `applied`=1.
- `cfg_waitrequest` held 1 for 5 cycles during the FRAC write -> `cfg_write`, addr 7 and data remain stable for 6 cycles, then exactly one accepted write.
- `sel_alt` toggles 1→0 during W_LOCK -> the first sequence completes; a second sequence writes 3639383488 to addr 7; final `applied`=0.
- `locked` stays 0 after the START write, `LOCK_TIMEOUT`=100 -> `error`=1 at the timeout, no `done`; the next trigger clears `error`.
- `reset` asserted in GAP1 -> `cfg_write`=0 and `busy`=0 asynchronously; after release with `sel_alt`=1, the full sequence reruns from W_MODE.
